// File: rtl/tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tx_frame_arbiter
//
// Frame-level arbiter that shares the single AXI-Stream TX path to the PHY-side
// axis_gmii_tx between two sources:
//   - CS: cross-layer-switch audio traffic (strict priority, low latency)
//   - PS: processing-system traffic, re-framed from GMII
// A PS wait counter overrides CS priority once PS has been held off for
// PS_MAX_WAIT cycles, so CS audio bursts cannot starve PS forever. A grant is
// only released after the granted source's tlast handshake, so frames are never
// interleaved.
//
// Ports:
//   clk, reset_n              TX clock, synchronous active-low reset
//   cs_enable                 CS may be granted (looked at only in IDLE)
//   s_cs_axis_*               CS source stream (tdata/tvalid/tready/tlast/tuser)
//   s_ps_axis_*               PS source stream (tdata/tvalid/tready/tlast/tuser)
//   m_axis_*                  merged stream towards axis_gmii_tx
//   grant_cs, grant_ps, busy  current grant status
//   cs_frame_count            completed CS frames (wrapping)
//   ps_frame_count            completed PS frames (wrapping)
//   ps_starve_count           PS grants issued by the starvation override (wrapping)
// -----------------------------------------------------------------------------
module tx_frame_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int PS_MAX_WAIT    = 1024,
    parameter int WAIT_CNT_WIDTH = 11,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs_enable,

    input  logic [DATA_WIDTH-1:0] s_cs_axis_tdata,
    input  logic                  s_cs_axis_tvalid,
    output logic                  s_cs_axis_tready,
    input  logic                  s_cs_axis_tlast,
    input  logic                  s_cs_axis_tuser,

    input  logic [DATA_WIDTH-1:0] s_ps_axis_tdata,
    input  logic                  s_ps_axis_tvalid,
    output logic                  s_ps_axis_tready,
    input  logic                  s_ps_axis_tlast,
    input  logic                  s_ps_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    output logic                  grant_cs,
    output logic                  grant_ps,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  cs_frame_count,
    output logic [CNT_WIDTH-1:0]  ps_frame_count,
    output logic [CNT_WIDTH-1:0]  ps_starve_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_CS = 2'd1,
        GRANT_PS = 2'd2
    } state_t;

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX = WAIT_CNT_WIDTH'(PS_MAX_WAIT);

    state_t                    state;
    state_t                    state_next;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_next;
    logic                      starve_grant;
    logic                      cs_done;
    logic                      ps_done;

    // Next-state decision and zero-latency datapath mux
    always_comb begin
        state_next       = state;
        starve_grant     = 1'b0;
        cs_done          = 1'b0;
        ps_done          = 1'b0;
        m_axis_tdata     = '0;
        m_axis_tvalid    = 1'b0;
        m_axis_tlast     = 1'b0;
        m_axis_tuser     = 1'b0;
        s_cs_axis_tready = 1'b0;
        s_ps_axis_tready = 1'b0;
        grant_cs         = 1'b0;
        grant_ps         = 1'b0;

        case (state)
            IDLE: begin
                // Starvation override beats CS priority; otherwise CS first.
                if (s_ps_axis_tvalid && (wait_cnt >= WAIT_MAX)) begin
                    state_next   = GRANT_PS;
                    starve_grant = 1'b1;
                end else if (s_cs_axis_tvalid && cs_enable) begin
                    state_next = GRANT_CS;
                end else if (s_ps_axis_tvalid) begin
                    state_next = GRANT_PS;
                end
            end
            GRANT_CS: begin
                grant_cs         = 1'b1;
                m_axis_tdata     = s_cs_axis_tdata;
                m_axis_tvalid    = s_cs_axis_tvalid;
                m_axis_tlast     = s_cs_axis_tlast;
                m_axis_tuser     = s_cs_axis_tuser;
                s_cs_axis_tready = m_axis_tready;
                if (s_cs_axis_tvalid && m_axis_tready && s_cs_axis_tlast) begin
                    state_next = IDLE;
                    cs_done    = 1'b1;
                end
            end
            GRANT_PS: begin
                grant_ps         = 1'b1;
                m_axis_tdata     = s_ps_axis_tdata;
                m_axis_tvalid    = s_ps_axis_tvalid;
                m_axis_tlast     = s_ps_axis_tlast;
                m_axis_tuser     = s_ps_axis_tuser;
                s_ps_axis_tready = m_axis_tready;
                if (s_ps_axis_tvalid && m_axis_tready && s_ps_axis_tlast) begin
                    state_next = IDLE;
                    ps_done    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy = grant_cs | grant_ps;
    end

    // PS wait counter: counts held-off PS cycles, cleared when PS goes quiet
    // or is granted, saturating at the override threshold.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (!s_ps_axis_tvalid) begin
            wait_cnt_next = '0;
        end else if ((state == IDLE) && (state_next == GRANT_PS)) begin
            wait_cnt_next = '0;
        end else if ((state != GRANT_PS) && (wait_cnt < WAIT_MAX)) begin
            wait_cnt_next = wait_cnt + WAIT_CNT_WIDTH'(1);
        end
    end

    // State, wait counter and frame statistics registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            cs_frame_count  <= '0;
            ps_frame_count  <= '0;
            ps_starve_count <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (cs_done) begin
                cs_frame_count <= cs_frame_count + CNT_WIDTH'(1);
            end
            if (ps_done) begin
                ps_frame_count <= ps_frame_count + CNT_WIDTH'(1);
            end
            if (starve_grant) begin
                ps_starve_count <= ps_starve_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_arbiter
//
// Drives both sources from per-source frame queues (AXI-compliant: a presented
// beat is held until accepted), keeps a frame-level reference of who owns the
// TX path, and compares every DUT output against it once per cycle on the
// falling edge. Small CNT_WIDTH and PS_MAX_WAIT make wrap and starvation
// reachable in a short run.
// -----------------------------------------------------------------------------
module tb_tx_frame_arbiter;

    localparam int DW   = 8;
    localparam int MAXW = 16;
    localparam int WCW  = 5;
    localparam int CW   = 4;
    localparam int CMOD = 1 << CW;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cs_enable;
    logic [DW-1:0] s_cs_axis_tdata;
    logic          s_cs_axis_tvalid;
    logic          s_cs_axis_tready;
    logic          s_cs_axis_tlast;
    logic          s_cs_axis_tuser;
    logic [DW-1:0] s_ps_axis_tdata;
    logic          s_ps_axis_tvalid;
    logic          s_ps_axis_tready;
    logic          s_ps_axis_tlast;
    logic          s_ps_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          grant_cs;
    logic          grant_ps;
    logic          busy;
    logic [CW-1:0] cs_frame_count;
    logic [CW-1:0] ps_frame_count;
    logic [CW-1:0] ps_starve_count;

    tx_frame_arbiter #(
        .DATA_WIDTH     (DW),
        .PS_MAX_WAIT    (MAXW),
        .WAIT_CNT_WIDTH (WCW),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cs_enable        (cs_enable),
        .s_cs_axis_tdata  (s_cs_axis_tdata),
        .s_cs_axis_tvalid (s_cs_axis_tvalid),
        .s_cs_axis_tready (s_cs_axis_tready),
        .s_cs_axis_tlast  (s_cs_axis_tlast),
        .s_cs_axis_tuser  (s_cs_axis_tuser),
        .s_ps_axis_tdata  (s_ps_axis_tdata),
        .s_ps_axis_tvalid (s_ps_axis_tvalid),
        .s_ps_axis_tready (s_ps_axis_tready),
        .s_ps_axis_tlast  (s_ps_axis_tlast),
        .s_ps_axis_tuser  (s_ps_axis_tuser),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .grant_cs         (grant_cs),
        .grant_ps         (grant_ps),
        .busy             (busy),
        .cs_frame_count   (cs_frame_count),
        .ps_frame_count   (ps_frame_count),
        .ps_starve_count  (ps_starve_count)
    );

    always #4 clk = ~clk;

    // Source frame queues (head = beat currently presented)
    beat_t cs_q[$];
    beat_t ps_q[$];

    // Reference: owner of the TX path (0 none, 1 CS, 2 PS), PS wait, counts
    int owner;
    int mwait;
    int m_cs, m_ps, m_st;

    // Stimulus knobs
    int cs_bub, ps_bub;   // percent chance a source idles a cycle
    int rdy_mode;         // 0: always ready, 1: random, 2: toggle
    bit tog;

    int n_cmp, n_err;
    logic [27:0] exp_vec, act_vec;

    task automatic push_frame(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d    = DW'($urandom);
            b.last = (i == len - 1);
            b.user = ($urandom_range(7) == 0);
            if (src == 1) cs_q.push_back(b);
            else          ps_q.push_back(b);
        end
    endtask

    // One clock: update the reference at the edge, drive new inputs, then
    // capture expected/actual output vectors at the falling edge.
    task automatic step();
        bit cs_hs, ps_hs;
        int nxt;
        bit e_tv, e_tl, e_tu;
        logic [DW-1:0] e_td;
        @(posedge clk);
        cs_hs = 1'b0;
        ps_hs = 1'b0;
        if (!reset_n) begin
            owner = 0; mwait = 0; m_cs = 0; m_ps = 0; m_st = 0;
        end else begin
            cs_hs = (owner == 1) && s_cs_axis_tvalid && m_axis_tready;
            ps_hs = (owner == 2) && s_ps_axis_tvalid && m_axis_tready;
            nxt = owner;
            if (owner == 0) begin
                if (s_ps_axis_tvalid && mwait >= MAXW) begin
                    nxt = 2; m_st = (m_st + 1) % CMOD;
                end else if (s_cs_axis_tvalid && cs_enable) nxt = 1;
                else if (s_ps_axis_tvalid) nxt = 2;
            end else if (cs_hs && s_cs_axis_tlast) begin
                nxt = 0; m_cs = (m_cs + 1) % CMOD;
            end else if (ps_hs && s_ps_axis_tlast) begin
                nxt = 0; m_ps = (m_ps + 1) % CMOD;
            end
            if (!s_ps_axis_tvalid) mwait = 0;
            else if (owner == 0 && nxt == 2) mwait = 0;
            else if (owner != 2 && mwait < MAXW) mwait++;
            if (cs_hs) void'(cs_q.pop_front());
            if (ps_hs) void'(ps_q.pop_front());
            owner = nxt;
        end
        #1;
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ($urandom_range(3) != 0);
            default: begin tog = ~tog; m_axis_tready = tog; end
        endcase
        if (cs_q.size() == 0) s_cs_axis_tvalid = 1'b0;
        else if (!(s_cs_axis_tvalid && !cs_hs)) s_cs_axis_tvalid = ($urandom_range(99) >= cs_bub);
        if (ps_q.size() == 0) s_ps_axis_tvalid = 1'b0;
        else if (!(s_ps_axis_tvalid && !ps_hs)) s_ps_axis_tvalid = ($urandom_range(99) >= ps_bub);
        {s_cs_axis_tdata, s_cs_axis_tlast, s_cs_axis_tuser} = (cs_q.size() != 0) ? cs_q[0] : '0;
        {s_ps_axis_tdata, s_ps_axis_tlast, s_ps_axis_tuser} = (ps_q.size() != 0) ? ps_q[0] : '0;
        @(negedge clk);
        e_tv = 1'b0; e_td = '0; e_tl = 1'b0; e_tu = 1'b0;
        if (owner == 1) {e_tv, e_td, e_tl, e_tu} = {s_cs_axis_tvalid, s_cs_axis_tdata, s_cs_axis_tlast, s_cs_axis_tuser};
        if (owner == 2) {e_tv, e_td, e_tl, e_tu} = {s_ps_axis_tvalid, s_ps_axis_tdata, s_ps_axis_tlast, s_ps_axis_tuser};
        exp_vec = {e_tv, e_td, e_tl, e_tu,
                   (owner == 1) && m_axis_tready, (owner == 2) && m_axis_tready,
                   owner == 1, owner == 2, owner != 0,
                   CW'(m_cs), CW'(m_ps), CW'(m_st)};
        act_vec = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                   s_cs_axis_tready, s_ps_axis_tready, grant_cs, grant_ps, busy,
                   cs_frame_count, ps_frame_count, ps_starve_count};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (act_vec !== exp_vec || act_vec !== 28'd0) begin
            n_err++; $display("FAIL reset_state got=%h exp=%h", act_vec, 28'd0);
        end
        reset_n = 1'b1;
        repeat (6) begin
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL reset_idle got=%h exp=%h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_cs_only();
        int c0;
        c0 = m_cs;
        push_frame(1, 60);
        repeat (72) begin
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL cs_only got=%h exp=%h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (cs_frame_count !== CW'((c0 + 1) % CMOD)) begin
            n_err++; $display("FAIL cs_only_count got=%0d exp=%0d", cs_frame_count, (c0 + 1) % CMOD);
        end
    endtask

    task automatic test_contention();
        int c0, p0;
        c0 = m_cs; p0 = m_ps;
        push_frame(1, 20);
        push_frame(2, 20);
        repeat (55) begin
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL contention got=%h exp=%h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if ({cs_frame_count, ps_frame_count} !== {CW'((c0 + 1) % CMOD), CW'((p0 + 1) % CMOD)}) begin
            n_err++; $display("FAIL contention_count got=%0d/%0d exp=%0d/%0d",
                              cs_frame_count, ps_frame_count, (c0 + 1) % CMOD, (p0 + 1) % CMOD);
        end
    endtask

    task automatic test_starvation();
        int s0;
        s0 = m_st;
        repeat (3) push_frame(1, 64);
        push_frame(2, 10);
        repeat (230) begin
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL starvation got=%h exp=%h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (ps_starve_count !== CW'((s0 + 1) % CMOD)) begin
            n_err++; $display("FAIL starve_count got=%0d exp=%0d", ps_starve_count, (s0 + 1) % CMOD);
        end
    endtask

    task automatic test_backpressure();
        rdy_mode = 2;
        push_frame(2, 30);
        repeat (6) begin
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL backpressure got=%h exp=%h", act_vec, exp_vec);
            end
        end
        push_frame(1, 10);
        repeat (90) begin
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL backpressure got=%h exp=%h", act_vec, exp_vec);
            end
            if (grant_ps && s_cs_axis_tready) begin
                n_err++; $display("FAIL no_switch got=cs_ready1 exp=cs_ready0");
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_cs_enable();
        cs_enable = 1'b0;
        push_frame(1, 12);
        repeat (8) begin
            step(); n_cmp++;
            if ({grant_cs, m_axis_tvalid} !== 2'b00 || act_vec !== exp_vec) begin
                n_err++; $display("FAIL cs_disabled got=%h exp=%h", act_vec, exp_vec);
            end
        end
        cs_enable = 1'b1;
        step(); n_cmp++;
        if (grant_cs !== 1'b1) begin
            n_err++; $display("FAIL cs_enable_grant got=%b exp=1", grant_cs);
        end
        repeat (20) begin
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL cs_enable_frame got=%h exp=%h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_midframe_reset();
        push_frame(2, 30);
        repeat (10) step();
        reset_n = 1'b0;
        cs_q.delete();
        ps_q.delete();
        s_ps_axis_tvalid = 1'b0;
        step(); n_cmp++;
        if (act_vec !== exp_vec || act_vec !== 28'd0) begin
            n_err++; $display("FAIL midframe_reset got=%h exp=%h", act_vec, 28'd0);
        end
        reset_n = 1'b1;
        repeat (4) begin
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL after_reset got=%h exp=%h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        int guard;
        cs_bub = 20; ps_bub = 20; rdy_mode = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cs_q.size() < 40 && $urandom_range(24) == 0) push_frame(1, $urandom_range(1, 40));
            if (ps_q.size() < 40 && $urandom_range(24) == 0) push_frame(2, $urandom_range(1, 40));
            if ($urandom_range(49) == 0) cs_enable = ~cs_enable;
            step(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
        end
        cs_bub = 0; ps_bub = 0; rdy_mode = 0; cs_enable = 1'b1;
        guard = 0;
        while ((cs_q.size() != 0 || ps_q.size() != 0 || owner != 0) && guard < 3000) begin
            step(); n_cmp++; guard++;
            if (act_vec !== exp_vec) begin
                n_err++; $display("FAIL drain got=%h exp=%h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (guard >= 3000) begin
            n_err++; $display("FAIL drain_timeout got=%0d exp=<3000", guard);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        owner = 0; mwait = 0; m_cs = 0; m_ps = 0; m_st = 0;
        cs_bub = 0; ps_bub = 0; rdy_mode = 0; tog = 1'b0;
        reset_n = 1'b0; cs_enable = 1'b1; m_axis_tready = 1'b1;
        s_cs_axis_tdata = '0; s_cs_axis_tvalid = 1'b0; s_cs_axis_tlast = 1'b0; s_cs_axis_tuser = 1'b0;
        s_ps_axis_tdata = '0; s_ps_axis_tvalid = 1'b0; s_ps_axis_tlast = 1'b0; s_ps_axis_tuser = 1'b0;
        test_reset();
        test_cs_only();
        test_contention();
        test_starvation();
        test_backpressure();
        test_cs_enable();
        test_midframe_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
